ysyx_24110015_mem_arbiter: RTL
==============================

YSYX_24110015_MEM_ARBITER -- requirements
Module: ysyx_24110015_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write strobe is DATA_W/8 bits.

REQ-002 Ports SHALL be (one AXI4-Lite channel per line; ready runs opposite to valid):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ifu_araddr/arvalid  in, ifu_arready  out  ADDR_W/1/1  IFU read-address channel.
- ifu_rdata/rresp/rvalid  out, ifu_rready  in  DATA_W/2/1/1  IFU read-data channel.
- lsu_araddr/arvalid  in, lsu_arready  out  ADDR_W/1/1  LSU read-address channel.
- lsu_rdata/rresp/rvalid  out, lsu_rready  in  DATA_W/2/1/1  LSU read-data channel.
- lsu_awaddr/awvalid  in, lsu_awready  out  ADDR_W/1/1  LSU write-address channel.
- lsu_wdata/wstrb/wvalid  in, lsu_wready  out  DATA_W/DATA_W/8/1/1  LSU write-data channel.
- lsu_bresp/bvalid  out, lsu_bready  in  2/1/1  LSU write-response channel.
- m_araddr/arvalid  out, m_arready  in  shared slave read-address channel.
- m_rdata/rresp/rvalid  in, m_rready  out  shared slave read-data channel.
- m_awaddr/awvalid  out, m_awready  in  shared slave write-address channel.
- m_wdata/wstrb/wvalid  out, m_wready  in  shared slave write-data channel.
- m_bresp/bvalid  in, m_bready  out  shared slave write-response channel.

Function
REQ-003 FSM states SHALL be IDLE, IFU_RD, LSU_RD, LSU_WR; the state is a register.

REQ-004 Arbitration SHALL happen in IDLE only, with fixed priority:
- LSU write (lsu_awvalid | lsu_wvalid) first, then lsu_arvalid, then ifu_arvalid.
- The winner becomes the state on the next posedge; with no request, the FSM stays in IDLE.

REQ-005 In IDLE all master-side ready/valid outputs and all m_* valid/ready outputs SHALL be 0.

REQ-006 IFU_RD SHALL connect the ports combinationally:
- m_araddr = ifu_araddr, m_arvalid = ifu_arvalid & ~ar_done, ifu_arready = m_arready & ~ar_done.
- ifu_rdata/rresp/rvalid = m_rdata/rresp/rvalid, m_rready = ifu_rready.

REQ-007 LSU_RD SHALL behave as REQ-006 with the lsu_* read ports in place of the ifu_* ports.

REQ-008 In LSU_WR, AW and W SHALL be forwarded independently and may complete in either order:
- m_awvalid = lsu_awvalid & ~aw_done, lsu_awready = m_awready & ~aw_done.
- m_wvalid = lsu_wvalid & ~w_done, lsu_wready = m_wready & ~w_done.
- The B channel is forwarded straight through (lsu_bresp/bvalid from m_*, m_bready from lsu_bready).

REQ-009 Flags ar_done, aw_done and w_done SHALL be registers:
- Each sets on its channel handshake.
- All clear on return to IDLE.
- They prevent a second address or data beat within one grant.

REQ-010 Grant release SHALL occur at the posedge of the completing handshake:
- Read states return to IDLE on m_rvalid & m_rready.
- LSU_WR returns to IDLE on m_bvalid & m_bready.

REQ-011 After every transaction there SHALL be exactly one IDLE cycle before the next grant, so the minimum spacing between transactions is one cycle.

REQ-012 Ungranted masters SHALL see all ready and valid outputs at 0, and their rdata/bresp outputs at 0.

REQ-013 Once granted, a master keeps the grant until its response handshake; requests from other masters in the meantime are neither granted nor dropped, they wait.

REQ-014 The block SHALL NOT modify address, data, strobe or response values, and SHALL NOT insert wait states on any channel beyond the IDLE cycle.

REQ-015 A response that arrives in the same cycle as its address handshake (zero-latency slave) SHALL be handled correctly: both handshakes complete and the FSM returns to IDLE.

Reset
REQ-016 While rst=1 at a posedge, the block SHALL:
- Go to IDLE and clear ar_done, aw_done and w_done.
- Drive every valid/ready output to 0 and every data/response output to 0 from the following cycle.

REQ-017 Reset asserted mid-transaction SHALL abandon the transaction; no response is forwarded to the master after reset.

Verification
REQ-018 IFU read alone:
- Stimulus: ifu_arvalid=1, araddr=0x80000000; slave arready after 2 cycles, rdata=0x00000413 one cycle later.
- Response: m_araddr=0x80000000; ifu_rvalid with rdata=0x00000413; FSM back in IDLE the cycle after the R handshake.

REQ-019 Simultaneous requests:
- Stimulus: ifu_arvalid and lsu_arvalid raised in the same cycle.
- Response: LSU_RD granted first; IFU arready held at 0 until LSU R completes plus one IDLE cycle, then IFU_RD granted.

REQ-020 LSU write, W before AW:
- Stimulus: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF; slave wready on cycle 1, awready on cycle 3, bvalid on cycle 4.
- Response: exactly one AW beat and one W beat reach the slave; lsu_bvalid with bresp=0; return to IDLE.

REQ-021 Zero-latency slave:
- Stimulus: m_arready and m_rvalid both 1 in the same cycle as arvalid.
- Response: IFU receives one R beat; FSM goes IFU_RD -> IDLE in one cycle.

REQ-022 Reset mid-transaction:
- Stimulus: rst pulsed while in LSU_WR with aw_done=1.
- Response: IDLE, all flags 0, all outputs 0 on the next cycle; a subsequent IFU read completes normally.

Source files
------------

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
//
// Shares one AXI4-Lite slave port between the instruction fetch unit (read
// only) and the load/store unit (read and write). One transaction is in
// flight at a time. A grant is taken in IDLE with fixed priority
// (LSU write > LSU read > IFU read) and held until the response handshake of
// that transaction, after which the FSM spends exactly one cycle in IDLE.
//
// While a master holds the grant, its channels are wired straight through to
// the slave port (no added wait states, no change to address, data, strobe or
// response values). The only gating is a per-channel done flag that blocks a
// second address or data beat inside one grant. Everything not belonging to
// the granted master is driven to 0.
//
// Handshake rule on every channel: a beat transfers on a posedge where valid
// and ready are both 1; the forwarding here never makes valid depend on ready
// of the same channel, so a slave that raises ready combinationally is safe.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ifu_ar*/ifu_r*           IFU read-address / read-data channels
//   lsu_ar*/lsu_r*           LSU read-address / read-data channels
//   lsu_aw*/lsu_w*/lsu_b*    LSU write-address / write-data / response
//   m_ar*/m_r*/m_aw*/m_w*/m_b* shared slave channels
//   dbg_state                current FSM state (0 IDLE, 1 IFU_RD, 2 LSU_RD,
//                            3 LSU_WR)
//   dbg_done                 {ar_done, aw_done, w_done}
// ---------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,

   // IFU read channels
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,

   // LSU read channels
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic                lsu_arvalid,
   output logic                lsu_arready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rvalid,
   input  logic                lsu_rready,

   // LSU write channels
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   input  logic                lsu_awvalid,
   output logic                lsu_awready,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   input  logic                lsu_wvalid,
   output logic                lsu_wready,
   output logic [1:0]          lsu_bresp,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,

   // Shared slave port
   output logic [ADDR_W-1:0]   m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,

   // Observation of internal state
   output logic [1:0]          dbg_state,
   output logic [2:0]          dbg_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } state_t;

   state_t state;
   logic   ar_done;
   logic   aw_done;
   logic   w_done;

   // Handshakes seen on the slave port. The valid/ready outputs used here are
   // already gated by state, so these can only fire for the granted master.
   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;

   assign ar_hs = m_arvalid & m_arready;
   assign r_hs  = m_rvalid  & m_rready;
   assign aw_hs = m_awvalid & m_awready;
   assign w_hs  = m_wvalid  & m_wready;
   assign b_hs  = m_bvalid  & m_bready;

   // ------------------------------------------------------------------------
   // State and done flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ar_done <= 1'b0;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               // Either half of a write is enough to claim the write grant;
               // the other half may show up later.
               if (lsu_awvalid | lsu_wvalid) begin
                  state <= LSU_WR;
               end else if (lsu_arvalid) begin
                  state <= LSU_RD;
               end else if (ifu_arvalid) begin
                  state <= IFU_RD;
               end
            end

            IFU_RD, LSU_RD: begin
               // The response handshake ends the grant even when it lands in
               // the same cycle as the address handshake (zero-latency slave);
               // the flag clears instead of setting in that case.
               if (r_hs) begin
                  state   <= IDLE;
                  ar_done <= 1'b0;
               end else if (ar_hs) begin
                  ar_done <= 1'b1;
               end
            end

            LSU_WR: begin
               if (b_hs) begin
                  state   <= IDLE;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end else begin
                  if (aw_hs) begin
                     aw_done <= 1'b1;
                  end
                  if (w_hs) begin
                     w_done <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               ar_done <= 1'b0;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Channel routing. Everything defaults to 0 so IDLE and every ungranted
   // master see idle channels with zeroed payload.
   // ------------------------------------------------------------------------
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = 2'b00;
      ifu_rvalid  = 1'b0;

      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = 2'b00;
      lsu_rvalid  = 1'b0;

      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = 2'b00;
      lsu_bvalid  = 1'b0;

      m_araddr    = '0;
      m_arvalid   = 1'b0;
      m_rready    = 1'b0;
      m_awaddr    = '0;
      m_awvalid   = 1'b0;
      m_wdata     = '0;
      m_wstrb     = '0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;

      case (state)
         IFU_RD: begin
            m_araddr    = ifu_araddr;
            m_arvalid   = ifu_arvalid & ~ar_done;
            ifu_arready = m_arready & ~ar_done;
            ifu_rdata   = m_rdata;
            ifu_rresp   = m_rresp;
            ifu_rvalid  = m_rvalid;
            m_rready    = ifu_rready;
         end

         LSU_RD: begin
            m_araddr    = lsu_araddr;
            m_arvalid   = lsu_arvalid & ~ar_done;
            lsu_arready = m_arready & ~ar_done;
            lsu_rdata   = m_rdata;
            lsu_rresp   = m_rresp;
            lsu_rvalid  = m_rvalid;
            m_rready    = lsu_rready;
         end

         LSU_WR: begin
            // AW and W run independently; either may finish first.
            m_awaddr    = lsu_awaddr;
            m_awvalid   = lsu_awvalid & ~aw_done;
            lsu_awready = m_awready & ~aw_done;
            m_wdata     = lsu_wdata;
            m_wstrb     = lsu_wstrb;
            m_wvalid    = lsu_wvalid & ~w_done;
            lsu_wready  = m_wready & ~w_done;
            lsu_bresp   = m_bresp;
            lsu_bvalid  = m_bvalid;
            m_bready    = lsu_bready;
         end

         default: begin
         end
      endcase
   end

   assign dbg_state = state;
   assign dbg_done  = {ar_done, aw_done, w_done};

endmodule
